// File: rtl/hub75_bcm_scan_if.sv
// Framebuffer read port of the HUB75 BCM scan engine.
// The scan engine (master) issues one read strobe per column with a
// column/row address. The framebuffer (slave) returns the top-half and
// bottom-half {R,G,B} pixels exactly one cycle later.
interface hub75_bcm_scan_if #(
  parameter int WIDTH     = 32,
  parameter int SCAN_ROWS = 16,
  parameter int BITS      = 4
);
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = $clog2(SCAN_ROWS);

  logic                fb_rd;
  logic [COL_W-1:0]    fb_col;
  logic [ROW_W-1:0]    fb_row;
  logic [3*BITS-1:0]   fb_top_rgb;
  logic [3*BITS-1:0]   fb_bot_rgb;

  modport master (
    output fb_rd, fb_col, fb_row,
    input  fb_top_rgb, fb_bot_rgb
  );

  modport slave (
    input  fb_rd, fb_col, fb_row,
    output fb_top_rgb, fb_bot_rgb
  );
endinterface

// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan: HUB75 1/N-scan display back end with binary-coded
// modulation. For each row and bit plane it fetches WIDTH pixel pairs from
// the framebuffer, shifts them out on r1..b2/clk_out, latches, then holds
// OE low for SHOW_BASE<<plane cycles.
// Optional feature: define HUB75_FRAME_SWAP_EN to enable end-of-frame
// framebuffer page swapping (frame_sel / swap_ack); otherwise both stay 0.
module hub75_bcm_scan #(
  parameter int WIDTH     = 32,
  parameter int SCAN_ROWS = 16,
  parameter int BITS      = 4,
  parameter int SHOW_BASE = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  hub75_bcm_scan_if.master              fb,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          frame_sel,
  output logic                          frame_start,
  output logic                          r1,
  output logic                          g1,
  output logic                          b1,
  output logic                          r2,
  output logic                          g2,
  output logic                          b2,
  output logic [$clog2(SCAN_ROWS)-1:0]  row_addr,
  output logic                          clk_out,
  output logic                          lat,
  output logic                          oe
);

  localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W   = $clog2(SCAN_ROWS);
  localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  // Wide enough for the longest plane (SHOW_BASE<<(BITS-1)) without wrap.
  localparam int SHOW_W  = $clog2(SHOW_BASE << (BITS - 1)) + 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(SCAN_ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DATA  = 3'd2,
    CLK   = 3'd3,
    LATCH = 3'd4,
    SHOW  = 3'd5,
    BLANK = 3'd6
  } state_t;

  state_t              state_r, state_next;
  logic [COL_W-1:0]    col_r, col_next;
  logic [ROW_W-1:0]    row_r, row_next;
  logic [PLANE_W-1:0]  plane_r, plane_next;
  logic [SHOW_W-1:0]   show_r, show_next;
  logic                swap_next;
  logic                eof_s;

  logic                fb_rd_r;
  logic [COL_W-1:0]    fb_col_r;
  logic [ROW_W-1:0]    fb_row_r;
  logic                frame_start_r;
  logic [ROW_W-1:0]    row_addr_r;
  logic                clk_out_r;
  logic                lat_r;
  logic                oe_r;
  logic                swap_ack_r;
  logic                frame_sel_r;
  logic [5:0]          data_r;
  logic [5:0]          pix_s;

  // Select the {R,G,B} bits of one bit plane from a packed pixel.
  function automatic logic [2:0] plane_bits(input logic [3*BITS-1:0] rgb,
                                            input logic [PLANE_W-1:0] p);
    plane_bits = {rgb[2*BITS + int'(p)], rgb[BITS + int'(p)], rgb[int'(p)]};
  endfunction

  assign eof_s = (plane_r == PLANE_LAST) && (row_r == ROW_LAST);
  assign pix_s = {plane_bits(fb.fb_top_rgb, plane_r), plane_bits(fb.fb_bot_rgb, plane_r)};

  // Next-state, counter and swap-decision logic of the scan sequencer.
  always_comb begin
    state_next = state_r;
    col_next   = col_r;
    row_next   = row_r;
    plane_next = plane_r;
    show_next  = show_r;
    swap_next  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next = FETCH;
          col_next   = '0;
          row_next   = '0;
          plane_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: state_next = DATA;
      DATA:  state_next = CLK;
      CLK: begin
        if (col_r == COL_LAST) begin
          col_next   = '0;
          state_next = LATCH;
        end else begin
          col_next   = col_r + COL_W'(1);
          state_next = FETCH;
        end
      end
      LATCH: begin
        state_next = SHOW;
        show_next  = (SHOW_W'(SHOW_BASE) << plane_r) - SHOW_W'(1);
      end
      SHOW: begin
        if (show_r == '0) begin
          state_next = BLANK;
        end else begin
          show_next  = show_r - SHOW_W'(1);
          state_next = SHOW;
        end
      end
      BLANK: begin
        if (plane_r != PLANE_LAST) begin
          plane_next = plane_r + PLANE_W'(1);
          state_next = FETCH;
        end else begin
          plane_next = '0;
          if (row_r != ROW_LAST) begin
            row_next   = row_r + ROW_W'(1);
            state_next = FETCH;
          end else begin
            // End of frame: a dropped enable takes effect only here.
            row_next   = '0;
            state_next = enable ? FETCH : IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef HUB75_FRAME_SWAP_EN
    // swap_req is taken at the edge that opens the frame's final BLANK so
    // that swap_ack and the new frame_sel are both visible during BLANK.
    if ((state_r == SHOW) && (state_next == BLANK) && eof_s && swap_req) begin
      swap_next = 1'b1;
    end else begin
      swap_next = 1'b0;
    end
`else
    swap_next = 1'b0;
`endif
  end

`ifndef HUB75_FRAME_SWAP_EN
  logic swap_req_unused_s;
  assign swap_req_unused_s = swap_req;
`endif

  // Sequencer state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      col_r   <= '0;
      row_r   <= '0;
      plane_r <= '0;
      show_r  <= '0;
    end else begin
      state_r <= state_next;
      col_r   <= col_next;
      row_r   <= row_next;
      plane_r <= plane_next;
      show_r  <= show_next;
    end
  end

  // Control outputs registered from the next state, so each is valid for
  // the whole cycle of the state it belongs to; row_addr moves only in LATCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_rd_r       <= 1'b0;
      fb_col_r      <= '0;
      fb_row_r      <= '0;
      frame_start_r <= 1'b0;
      row_addr_r    <= '0;
      clk_out_r     <= 1'b0;
      lat_r         <= 1'b0;
      oe_r          <= 1'b1;
      swap_ack_r    <= 1'b0;
      frame_sel_r   <= 1'b0;
      data_r        <= 6'b000000;
    end else begin
      fb_rd_r       <= (state_next == FETCH);
      fb_col_r      <= (state_next == FETCH) ? col_next : fb_col_r;
      fb_row_r      <= (state_next == FETCH) ? row_next : fb_row_r;
      frame_start_r <= (state_next == FETCH) && (col_next == '0) &&
                       (row_next == '0) && (plane_next == '0);
      row_addr_r    <= (state_next == LATCH) ? row_next : row_addr_r;
      clk_out_r     <= (state_next == CLK);
      lat_r         <= (state_next == LATCH);
      oe_r          <= (state_next != SHOW);
      swap_ack_r    <= swap_next;
      frame_sel_r   <= frame_sel_r ^ swap_next;
      data_r        <= (state_r == DATA) ? pix_s : data_r;
    end
  end

  // Panel data follows the framebuffer during DATA (one full cycle ahead of
  // the clk_out rising edge) and is held from the register afterwards.
  assign {r1, g1, b1, r2, g2, b2} = (state_r == DATA) ? pix_s : data_r;

  assign fb.fb_rd     = fb_rd_r;
  assign fb.fb_col    = fb_col_r;
  assign fb.fb_row    = fb_row_r;
  assign frame_start  = frame_start_r;
  assign row_addr     = row_addr_r;
  assign clk_out      = clk_out_r;
  assign lat          = lat_r;
  assign oe           = oe_r;
  assign swap_ack     = swap_ack_r;
  assign frame_sel    = frame_sel_r;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed testbench for hub75_bcm_scan with WIDTH=4, SCAN_ROWS=2, BITS=2,
// SHOW_BASE=4. Expected per-cycle control/data values come from the plane
// schedule (12 shift cycles, LATCH, 4 or 8 SHOW cycles, BLANK).
module tb_hub75_bcm_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       swap_req;
  logic       swap_ack, frame_sel, frame_start;
  logic       r1, g1, b1, r2, g2, b2;
  logic [0:0] row_addr;
  logic       clk_out, lat, oe;

  int n_checks = 0;
  int n_fail   = 0;

  hub75_bcm_scan_if #(.WIDTH(4), .SCAN_ROWS(2), .BITS(2)) fb_if ();

  hub75_bcm_scan #(.WIDTH(4), .SCAN_ROWS(2), .BITS(2), .SHOW_BASE(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fb(fb_if),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_sel(frame_sel),
    .frame_start(frame_start), .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2),
    .b2(b2), .row_addr(row_addr), .clk_out(clk_out), .lat(lat), .oe(oe)
  );

  always #5 clk = ~clk;

  // Framebuffer model: page 0 top = {01,10,11}, page 1 top = {10,01,00},
  // bottom = {11,00,10} on both pages; one-cycle read latency.
  always @(posedge clk) begin
    if (fb_if.fb_rd) begin
      fb_if.fb_top_rgb <= frame_sel ? 6'b100100 : 6'b011011;
      fb_if.fb_bot_rgb <= 6'b110010;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_low = 0;
    int clk_cnt = 0;
    int ra_exp = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", oe, 1);
    check("rst_outs", {r1, g1, b1, r2, g2, b2, row_addr, clk_out, lat, fb_if.fb_rd,
                       fb_if.fb_col, fb_if.fb_row, swap_ack, frame_sel, frame_start}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_enable", {fb_if.fb_rd, oe, frame_start}, 3'b010);
    enable = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 260; t++) begin
      int tf, row, p, plane, off, show, phase, col, sel_exp, ack_exp;
      logic [5:0] dexp;
      if (t > 0) begin
        @(posedge clk); #1;
      end
      tf    = t % 80;
      row   = tf / 40;
      p     = tf % 40;
      plane = (p < 18) ? 0 : 1;
      off   = plane ? p - 18 : p;
      show  = plane ? 8 : 4;
      col   = off / 3;
      // phase: 0 FETCH, 1 DATA, 2 CLK, 3 LATCH, 4 SHOW, 5 BLANK, 6 IDLE
      if (t >= 240)             phase = 6;
      else if (off < 12)        phase = off % 3;
      else if (off == 12)       phase = 3;
      else if (off <= 12 + show) phase = 4;
      else                      phase = 5;

`ifdef HUB75_FRAME_SWAP_EN
      sel_exp = (t >= 79) ? 1 : 0;
      ack_exp = (t == 79) ? 1 : 0;
`else
      sel_exp = 0;
      ack_exp = 0;
`endif

      check($sformatf("ctl@%0d", t), {fb_if.fb_rd, clk_out, lat, oe, frame_start},
            {phase == 0, phase == 2, phase == 3, phase != 4, (phase == 0) && (tf == 0)});
      if (phase == 3) ra_exp = row;
      check($sformatf("row_addr@%0d", t), row_addr, ra_exp);
      check($sformatf("swap@%0d", t), {frame_sel, swap_ack}, {sel_exp[0], ack_exp[0]});
      if (phase == 0) begin
        check($sformatf("fb_addr@%0d", t), {fb_if.fb_col, fb_if.fb_row}, {col[1:0], row[0]});
      end
      if (phase == 1 || phase == 2) begin
        case ({sel_exp[0], plane[0]})
          2'b00:   dexp = 6'b101100;
          2'b01:   dexp = 6'b011101;
          2'b10:   dexp = 6'b010100;
          default: dexp = 6'b100101;
        endcase
        check($sformatf("data@%0d", t), {r1, g1, b1, r2, g2, b2}, dexp);
      end
      if (t < 80) begin
        if (!oe) oe_low++;
        if (clk_out) clk_cnt++;
      end
      if (t == 5)   swap_req = 1'b1;
      if (t == 80)  swap_req = 1'b0;
      if (t == 205) enable = 1'b0;
    end

    check("oe_low_frame1", oe_low, 24);
    check("clk_pulses_frame1", clk_cnt, 16);

    enable = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrun_rst_oe", oe, 1);
    check("midrun_rst_outs", {r1, g1, b1, r2, g2, b2, row_addr, clk_out, lat, fb_if.fb_rd,
                              fb_if.fb_col, fb_if.fb_row, swap_ack, frame_sel, frame_start}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
